// File: rtl/systolic_fir_if.sv
// rtl/systolic_fir_if.sv - Coefficient, sample and result signals of systolic_fir
interface systolic_fir_if #(
  parameter int DW = 10,
  parameter int CW = 10,
  parameter int OW = 12
);
  logic          coef_load;
  logic          coef_valid;
  logic [CW-1:0] coef_in;
  logic          din_valid;
  logic [DW-1:0] din;
  logic          din_ready;
  logic          dout_valid;
  logic [OW-1:0] dout;
  logic          sat;

  modport master (
    output coef_load, coef_valid, coef_in, din_valid, din,
    input  din_ready, dout_valid, dout, sat
  );

  modport slave (
    input  coef_load, coef_valid, coef_in, din_valid, din,
    output din_ready, dout_valid, dout, sat
  );
endinterface

// File: rtl/systolic_fir.sv
// rtl/systolic_fir.sv - Transposed-form systolic FIR with loadable coefficients
// and a rounded, saturated output stage.
module systolic_fir #(
  parameter int NTAPS = 8,
  parameter int DW    = 10,
  parameter int CW    = 10,
  parameter int ACCW  = 23,
  parameter int SHIFT = 9,
  parameter int OW    = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  systolic_fir_if.slave bus
);

  localparam int CNTW = $clog2(NTAPS);
  localparam int PW   = DW + CW;
  localparam logic [CNTW-1:0]        LAST = CNTW'(NTAPS - 1);
  localparam logic signed [ACCW-1:0] RND  = {{(ACCW-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [ACCW-1:0] OMAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] OMIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            w_coef_we;
  logic            w_flush;
  logic            w_accept;

  logic signed [CW-1:0]   r_coef [NTAPS];
  logic signed [DW-1:0]   r_x;
  logic signed [ACCW-1:0] r_p    [NTAPS];
  logic                   r_v1;
  logic                   r_v2;
  logic [OW-1:0]          r_dout;
  logic                   r_dout_valid;
  logic                   r_sat;

  logic signed [PW-1:0]   w_prod [NTAPS];
  logic signed [ACCW-1:0] w_ext  [NTAPS];
  logic signed [ACCW-1:0] w_psum [NTAPS];
  logic signed [ACCW-1:0] w_rnd;
  logic signed [ACCW-1:0] w_shf;
  logic                   w_hi;
  logic                   w_lo;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_coef_we   = 1'b0;
    w_flush     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (bus.coef_load) begin
          w_cnt_nxt = '0;
        end else if (bus.coef_valid) begin
          w_coef_we = 1'b1;
          if (r_cnt == LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_RUN;
          end else begin
            w_cnt_nxt = r_cnt + CNTW'(1);
          end
        end
      end
      S_RUN: begin
        // A reload wins over a sample presented in the same cycle.
        if (bus.coef_load) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
          w_flush     = 1'b1;
        end else if (bus.din_valid) begin
          w_accept = 1'b1;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NTAPS; k++) r_coef[k] <= '0;
    end else if (w_coef_we) begin
      r_coef[r_cnt] <= $signed(bus.coef_in);
    end
  end

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    assign w_prod[k] = PW'(r_coef[k]) * PW'(r_x);
    assign w_ext[k]  = {{(ACCW-PW){w_prod[k][PW-1]}}, w_prod[k]};
    if (k == NTAPS - 1) begin : g_last
      assign w_psum[k] = w_ext[k];
    end else begin : g_mid
      assign w_psum[k] = w_ext[k] + r_p[k+1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x  <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      for (int k = 0; k < NTAPS; k++) r_p[k] <= '0;
    end else if (w_flush) begin
      r_x  <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      for (int k = 0; k < NTAPS; k++) r_p[k] <= '0;
    end else begin
      r_v1 <= w_accept;
      r_v2 <= r_v1;
      if (w_accept) r_x <= $signed(bus.din);
      // The chain only moves on accepted samples, so input gaps are harmless.
      if (r_v1) begin
        for (int k = 0; k < NTAPS; k++) r_p[k] <= w_psum[k];
      end
    end
  end

  assign w_rnd = r_p[0] + RND;
  assign w_shf = w_rnd >>> SHIFT;
  assign w_hi  = (w_shf > OMAX);
  assign w_lo  = (w_shf < OMIN);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_sat        <= 1'b0;
    end else if (w_flush || !r_v2) begin
      r_dout_valid <= 1'b0;
      r_sat        <= 1'b0;
    end else begin
      r_dout_valid <= 1'b1;
      r_sat        <= w_hi | w_lo;
      if (w_hi)      r_dout <= OMAX[OW-1:0];
      else if (w_lo) r_dout <= OMIN[OW-1:0];
      else           r_dout <= w_shf[OW-1:0];
    end
  end

  assign bus.din_ready  = (r_state == S_RUN);
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.sat        = r_sat;

endmodule

// File: tb/tb_systolic_fir.sv
// tb/tb_systolic_fir.sv - Directed and randomized checks of systolic_fir against
// a convolution reference model.
module tb_systolic_fir;
  localparam int NTAPS = 8;
  localparam int DW    = 10;
  localparam int CW    = 10;
  localparam int ACCW  = 23;
  localparam int SHIFT = 9;
  localparam int OW    = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_fir_if #(.DW(DW), .CW(CW), .OW(OW)) bus ();

  systolic_fir #(
    .NTAPS(NTAPS), .DW(DW), .CW(CW), .ACCW(ACCW), .SHIFT(SHIFT), .OW(OW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    int            due;
    logic [OW-1:0] dout;
    logic          sat;
  } exp_t;

  exp_t          exp_q[$];
  logic [OW:0]   obs_q[$];
  int            hist[$];
  int            m_coef[NTAPS];
  bit            m_run;
  int            m_cnt;
  logic [OW-1:0] m_last;
  int            cyc;
  int            checks;
  int            errors;

  int c1[NTAPS]    = '{64, -128, 200, 511, 511, 200, -128, 64};
  int s1[NTAPS]    = '{32, -64, 100, 256, 256, 100, -64, 32};
  int c_max[NTAPS] = '{default: 511};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic model_sample(input int x);
    int   acc;
    int   num;
    int   q;
    exp_t e;
    hist.push_front(x);
    if (hist.size() > NTAPS) void'(hist.pop_back());
    acc = 0;
    foreach (hist[k]) acc += m_coef[k] * hist[k];
    num = acc + (1 << (SHIFT - 1));
    q   = num / (1 << SHIFT);
    if ((num % (1 << SHIFT)) != 0 && num < 0) q = q - 1;
    e.sat = 1'b0;
    if (q > (1 << (OW - 1)) - 1) begin
      q = (1 << (OW - 1)) - 1;
      e.sat = 1'b1;
    end else if (q < -(1 << (OW - 1))) begin
      q = -(1 << (OW - 1));
      e.sat = 1'b1;
    end
    e.dout = q[OW-1:0];
    e.due  = cyc + 3;
    exp_q.push_back(e);
  endtask

  task automatic model_edge(input logic cl, input logic cv, input logic [CW-1:0] ci,
                            input logic dv, input logic [DW-1:0] d);
    if (!m_run) begin
      if (cl) begin
        m_cnt = 0;
      end else if (cv) begin
        m_coef[m_cnt] = int'($signed(ci));
        m_cnt++;
        if (m_cnt == NTAPS) begin
          m_cnt = 0;
          m_run = 1'b1;
        end
      end
    end else begin
      if (cl) begin
        m_run = 1'b0;
        m_cnt = 0;
        hist.delete();
        exp_q.delete();
      end else if (dv) begin
        model_sample(int'($signed(d)));
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("dout_valid", 32'(bus.dout_valid), 32'd1);
      chk("dout", 32'(bus.dout), 32'(e.dout));
      chk("sat", 32'(bus.sat), 32'(e.sat));
      m_last = e.dout;
    end else begin
      chk("dout_valid_idle", 32'(bus.dout_valid), 32'd0);
      chk("dout_hold", 32'(bus.dout), 32'(m_last));
      chk("sat_idle", 32'(bus.sat), 32'd0);
    end
    chk("din_ready", 32'(bus.din_ready), 32'(m_run));
    if (bus.dout_valid === 1'b1) obs_q.push_back({bus.sat, bus.dout});
  endtask

  task automatic drive(input logic cl, input logic cv, input logic [CW-1:0] ci,
                       input logic dv, input logic [DW-1:0] d);
    bus.coef_load  = cl;
    bus.coef_valid = cv;
    bus.coef_in    = ci;
    bus.din_valid  = dv;
    bus.din        = d;
    model_edge(cl, cv, ci, dv, d);
    tick();
    bus.coef_load  = 1'b0;
    bus.coef_valid = 1'b0;
    bus.coef_in    = '0;
    bus.din_valid  = 1'b0;
    bus.din        = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic load_words(input int c[NTAPS], input int first, input int n);
    for (int k = first; k < first + n; k++) drive(1'b0, 1'b1, CW'(c[k]), 1'b0, '0);
  endtask

  task automatic load(input int c[NTAPS]);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    load_words(c, 0, NTAPS);
  endtask

  task automatic impulse(input bit gaps);
    drive(1'b0, 1'b0, '0, 1'b1, DW'(256));
    if (gaps) idle(1);
    for (int i = 1; i < NTAPS; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1, '0);
      if (gaps) idle(1);
    end
    idle(3);
  endtask

  task automatic chk_table(input string tag, input int vals[NTAPS]);
    logic [OW-1:0] v;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(NTAPS));
    for (int i = 0; i < NTAPS && i < obs_q.size(); i++) begin
      v = vals[i][OW-1:0];
      chk(tag, 32'(obs_q[i]), 32'({1'b0, v}));
    end
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_sat", 32'(bus.sat), 32'd0);
    chk("rst_din_ready", 32'(bus.din_ready), 32'd0);
    m_run  = 1'b0;
    m_cnt  = 0;
    m_coef = '{default: 0};
    m_last = '0;
    hist.delete();
    exp_q.delete();
    @(posedge clk);
    cyc++;
    #2 rst = 1'b0;
  endtask

  initial begin
    logic          cl;
    logic          cv;
    logic          dv;
    logic [CW-1:0] ci;
    logic [DW-1:0] d;
    int            cr[NTAPS];

    checks = 0;
    errors = 0;
    cyc    = 0;
    bus.coef_load  = 1'b0;
    bus.coef_valid = 1'b0;
    bus.coef_in    = '0;
    bus.din_valid  = 1'b0;
    bus.din        = '0;
    async_reset();

    obs_q.delete();
    load(c1);
    impulse(1'b0);
    chk_table("s1_impulse", s1);

    obs_q.delete();
    load(c_max);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, '0, 1'b1, DW'(511));
    idle(3);
    chk("s2_count", 32'(obs_q.size()), 32'd12);
    chk("s2_first", 32'(obs_q[0]), 32'({1'b0, 12'd510}));
    chk("s2_fourth", 32'(obs_q[3]), 32'({1'b0, 12'd2040}));
    chk("s2_fifth", 32'(obs_q[4]), 32'({1'b1, 12'd2047}));
    for (int i = 7; i < 12; i++) chk("s2_steady", 32'(obs_q[i]), 32'({1'b1, 12'd2047}));

    obs_q.delete();
    load(c_max);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, '0, 1'b1, DW'(-512));
    idle(3);
    chk("s3_steady", 32'(obs_q[11]), 32'({1'b1, 12'h800}));

    obs_q.delete();
    load(c1);
    impulse(1'b1);
    chk_table("s4_gapped", s1);

    obs_q.delete();
    drive(1'b0, 1'b0, '0, 1'b1, DW'(256));
    drive(1'b0, 1'b0, '0, 1'b1, DW'(100));
    drive(1'b1, 1'b0, '0, 1'b1, DW'(200));
    idle(4);
    chk("s5_dropped", 32'(obs_q.size()), 32'd0);
    load(c1);
    impulse(1'b0);
    chk_table("s5_replay", s1);

    load_words(c1, 0, 0);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    load_words(c1, 0, 3);
    async_reset();
    load_words(c1, 0, NTAPS - 1);
    chk("s6_not_ready", 32'(bus.din_ready), 32'd0);
    load_words(c1, NTAPS - 1, 1);
    chk("s6_ready", 32'(bus.din_ready), 32'd1);
    drive(1'b0, 1'b0, '0, 1'b1, DW'(256));
    drive(1'b0, 1'b0, '0, 1'b1, DW'(300));
    async_reset();
    obs_q.delete();
    load(c1);
    impulse(1'b0);
    chk_table("s6_after_reset", s1);

    for (int r = 0; r < 3; r++) begin
      foreach (cr[k]) cr[k] = int'($urandom_range(0, 1023)) - 512;
      load(cr);
      for (int i = 0; i < 40; i++)
        drive(1'b0, 1'b0, '0, 1'($urandom_range(0, 1)), DW'($urandom_range(0, 1023)));
    end
    for (int i = 0; i < 300; i++) begin
      cl = ($urandom_range(0, 31) == 0);
      cv = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      ci = CW'($urandom_range(0, 1023));
      d  = DW'($urandom_range(0, 1023));
      drive(cl, cv, ci, dv, d);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/systolic_fir.md
Name: systolic_fir

Overview:
- Downstream consumer of the sample memory: takes the 10-bit signed sample stream and produces filtered output samples.
- Pipelined transposed-form systolic FIR with NTAPS taps and run-time loadable coefficients.
- Output is rounded, right-shifted and saturated to OW bits.
- Small FSM separates coefficient loading from filtering.

Parameters:
- NTAPS, 8, number of taps (power of two, 2..32)
- DW, 10, signed input sample width
- CW, 10, signed coefficient width
- ACCW, 23, accumulator width (DW+CW+log2(NTAPS))
- SHIFT, 9, arithmetic right shift applied to the accumulator before saturation
- OW, 12, signed output width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- coef_load  in  1  one-cycle pulse: enter LOAD, restart coefficient count
- coef_valid  in  1  coef_in valid this cycle
- coef_in  in  CW  signed coefficient word
- din_valid  in  1  din valid this cycle
- din  in  DW  signed sample (from the sample memory's rdata)
- din_ready  out  1  high iff state==RUN
- dout_valid  out  1  one-cycle pulse per output sample
- dout  out  OW  signed filtered sample
- sat  out  1  high with dout_valid when the output was clipped

Behaviour:
- Reset (async, rst=1): state=LOAD, cnt=0, all c[k]=0, x_r=0, all p[k]=0, v1=v2=0, dout=0, dout_valid=0, sat=0, din_ready=0.
- States: LOAD, RUN.
- LOAD:
  - Each edge with coef_valid=1 writes c[cnt]<=coef_in and increments cnt.
  - When the NTAPS-th word is written, the next state is RUN and cnt returns to 0.
  - din_valid is ignored.
  - coef_load=1 in LOAD sets cnt=0 and discards any coef word presented in the same cycle.
- RUN:
  - coef_valid is ignored.
  - coef_load=1 causes: state<=LOAD, cnt<=0, x_r, p[*], v1, v2 cleared, dout_valid<=0. In-flight samples are dropped and dout holds its last value.
  - coef_load has priority over a simultaneous din_valid; that sample is dropped.
- Pipeline in RUN, with the sample accepted at edge t (din_valid=1):
  - Edge t: x_r<=din; v1<=1. Otherwise v1<=0.
  - Edge t+1, if v1: p[k]<=c[k]*x_r + p[k+1] for k=0..NTAPS-1, with p[NTAPS]=0; v2<=1. Otherwise p holds and v2<=0.
  - Edge t+2, if v2: dout<=sat_OW((p[0] + 2^(SHIFT-1)) >>> SHIFT); dout_valid<=1; sat<=clip flag. Otherwise dout_valid<=0, sat<=0, and dout holds.
- Latency is 2 cycles from acceptance to dout_valid. Full throughput: one sample per cycle, back-to-back.
- The partial-sum chain advances only on accepted samples, so gaps in din_valid do not disturb the result.
- Arithmetic:
  - Products are full-precision signed DW+CW bits, sign-extended to ACCW.
  - ACCW is sized so the sum cannot overflow.
  - Rounding is round-half-up (toward +inf) before the arithmetic shift.
  - Saturation range is [-2^(OW-1), 2^(OW-1)-1].
- Startup: p starts at zero, so the first NTAPS-1 outputs after reset or reload are partial sums. They are still flagged valid.
- An async reset mid-operation takes effect immediately and overrides everything, including pending outputs.

Test Plan:
1. Reset, then load c=[64,-128,200,511,511,200,-128,64], then drive an impulse din=256 followed by 7 zeros.
   -> dout sequence 32,-64,100,256,256,100,-64,32, with sat=0 throughout.
   -> The first dout_valid appears 2 cycles after the impulse is accepted.
2. Load all c=511, then drive 12 consecutive din=511.
   -> From the 8th output onward, dout=2047 with sat=1. Earlier outputs are unclipped partial sums: 1st=510, 4th=2040, 5th=2047 sat=1.
3. Load all c=511, then drive din=-512 continuously.
   -> Steady-state dout=-2048 with sat=1.
4. Repeat scenario 1 with din_valid low on alternate cycles.
   -> The same 8 output values are produced, each exactly 2 cycles after its accepted sample.
5. Pulse coef_load while 2 samples are in flight, in the same cycle as a din_valid.
   -> No further dout_valid; din_ready drops the next cycle.
   -> After reloading scenario 1's coefficients and replaying the impulse, the output matches scenario 1.
6. Assert rst mid-LOAD (after 3 coefficient words) and mid-RUN.
   -> All outputs return to 0 immediately and state returns to LOAD.
   -> 8 new words are required before din_ready=1.
